// File: rtl/n_lane_capture_probe_pkg.sv
// Shared state type, ASCII constants and hex helpers for the n-lane capture probe.
package n_lane_capture_probe_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    POST  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [7:0] ASC_SPACE = 8'h20;
  localparam logic [7:0] ASC_LF    = 8'h0A;
  localparam logic [7:0] ASC_X     = 8'h58;
  localparam logic [7:0] ASC_ZERO  = 8'h30;
  localparam logic [7:0] ASC_A     = 8'h41;

  function automatic int hex_digits(input int width);
    return (width + 3) / 4;
  endfunction

  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return ASC_ZERO + {4'd0, nib};
    else             return ASC_A + {4'd0, nib} - 8'd10;
  endfunction

endpackage

// File: rtl/n_lane_capture_probe_capture_ram.sv
// Simple dual-port sample memory: one write port, one read port with a
// registered (1-cycle) read that holds its output until the next read.
module capture_ram #(
  parameter int WIDTH     = 8,
  parameter int ADDR_BITS = 4
) (
  input  logic                 clk_sys,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [WIDTH-1:0]     rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk_sys) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/n_lane_capture_probe.sv
// Captures NUM_LANES lane streams into a circular memory and drains the window as ASCII hex.
// Define N_LANE_CAPTURE_PROBE_TRIGGER_EN for the mask/pattern trigger; otherwise the window is the first DEPTH samples after arming.
//
// state | meaning
// IDLE  | pause counter runs while arm_en is high
// ARM   | writing pre-trigger history, waiting for an accepted trigger
// POST  | writing the samples that follow the trigger
// DRAIN | streaming the window out as hex text
module n_lane_capture_probe
  import n_lane_capture_probe_pkg::*;
#(
  parameter int NUM_LANES    = 4,
  parameter int LANE_WIDTH   = 66,
  parameter int ADDR_BITS    = 10,
  parameter int PRE_TRIG     = 64,
  parameter int PAUSE_CYCLES = 32
) (
  input  logic                            clk_sys,
  input  logic                            arst_sys_n,
  input  logic [NUM_LANES*LANE_WIDTH-1:0] lane_dat,
  input  logic [NUM_LANES-1:0]            lane_valid,
  input  logic                            arm_en,
  input  logic [LANE_WIDTH-1:0]           trig_pattern,
  input  logic [LANE_WIDTH-1:0]           trig_mask,
  input  logic [NUM_LANES-1:0]            trig_lane_en,
  output logic [7:0]                      dout,
  output logic                            dout_valid,
  input  logic                            dout_ready,
  output logic                            reporting,
  output logic                            triggered
);

  localparam int DEPTH      = 2**ADDR_BITS;
  localparam int WORD_W     = NUM_LANES * (LANE_WIDTH + 1);
  localparam int HEX_DIGITS = hex_digits(LANE_WIDTH);
  localparam int POST_LEN   = DEPTH - PRE_TRIG - 1;
  localparam int PAUSE_W    = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;
  localparam int FILL_W     = (PRE_TRIG > 0) ? $clog2(PRE_TRIG + 1) : 1;
  localparam int LANE_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int DIG_W      = $clog2(HEX_DIGITS + 1);

  localparam logic [PAUSE_W-1:0]   PAUSE_LAST = PAUSE_W'(PAUSE_CYCLES - 1);
  localparam logic [FILL_W-1:0]    FILL_SAT   = FILL_W'(PRE_TRIG);
  localparam logic [ADDR_BITS-1:0] POST_LAST  = ADDR_BITS'(POST_LEN - 1);
  localparam logic [ADDR_BITS-1:0] PRE_OFS    = ADDR_BITS'(PRE_TRIG);
  localparam logic [LANE_W-1:0]    LANE_LAST  = LANE_W'(NUM_LANES - 1);
  localparam logic [DIG_W-1:0]     DIG_SEP    = DIG_W'(HEX_DIGITS);

  state_t state, state_nxt;

  logic [PAUSE_W-1:0]   pause_cnt;
  logic [FILL_W-1:0]    fill_cnt;
  logic [ADDR_BITS-1:0] wptr, trig_addr, post_cnt;
  logic                 trig_hit, trig_accept, pause_done, post_done, drain_done;
  logic                 ram_we;

  // drain-side pipeline: RAM read -> next word (RAM output reg) -> current word -> dout
  logic [ADDR_BITS:0]      rd_cnt;
  logic [ADDR_BITS-1:0]    start_addr, raddr;
  logic [WORD_W-1:0]       rdata, cur_word;
  logic                    nxt_valid, nxt_last, cur_valid, cur_last, out_last;
  logic [LANE_W-1:0]       lane_idx;
  logic [DIG_W-1:0]        dig_idx;
  logic                    emit, last_byte, load_cur, issue_rd;
  logic [7:0]              byte_nxt;
  logic [HEX_DIGITS*4-1:0] lane_bits;
  logic                    lane_ok;
  logic [3:0]              nib;

`ifdef N_LANE_CAPTURE_PROBE_TRIGGER_EN
  always_comb begin
    trig_hit = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (trig_lane_en[i] && lane_valid[i] &&
          ((lane_dat[i*LANE_WIDTH +: LANE_WIDTH] & trig_mask) == (trig_pattern & trig_mask)))
        trig_hit = 1'b1;
    end
  end
`else
  logic unused_trig;
  assign unused_trig = ^{trig_pattern, trig_mask, trig_lane_en};
  assign trig_hit    = 1'b1;
`endif

  // fill_cnt saturates at PRE_TRIG, so equality means the history is full
  assign trig_accept = trig_hit && (fill_cnt == FILL_SAT);
  assign pause_done  = (pause_cnt == PAUSE_LAST);
  assign post_done   = (post_cnt == POST_LAST);
  assign ram_we      = (state == ARM) || (state == POST);
  assign reporting   = (state == DRAIN);

  always_ff @(posedge clk_sys or negedge arst_sys_n) begin
    if (!arst_sys_n) state <= IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (arm_en && pause_done) state_nxt = ARM;
      ARM: begin
        if (!arm_en)          state_nxt = IDLE;
        else if (trig_accept) state_nxt = (POST_LEN == 0) ? DRAIN : POST;
      end
      POST:  if (post_done) state_nxt = DRAIN;
      DRAIN: if (drain_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge arst_sys_n) begin
    if (!arst_sys_n) begin
      pause_cnt <= '0;
      fill_cnt  <= '0;
      wptr      <= '0;
      trig_addr <= '0;
      post_cnt  <= '0;
      triggered <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arm_en) begin
            if (pause_done) begin
              pause_cnt <= '0;
              wptr      <= '0;
              fill_cnt  <= '0;
            end else begin
              pause_cnt <= pause_cnt + 1'b1;
            end
          end
        end
        ARM: begin
          wptr <= wptr + 1'b1;
          if (fill_cnt != FILL_SAT) fill_cnt <= fill_cnt + 1'b1;
          if (arm_en && trig_accept) begin
            trig_addr <= wptr;
            triggered <= 1'b1;
            post_cnt  <= '0;
          end
        end
        POST: begin
          wptr     <= wptr + 1'b1;
          post_cnt <= post_cnt + 1'b1;
        end
        DRAIN: begin
          if (drain_done) begin
            triggered <= 1'b0;
            pause_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  capture_ram #(
    .WIDTH     (WORD_W),
    .ADDR_BITS (ADDR_BITS)
  ) u_capture_ram (
    .clk_sys (clk_sys),
    .we      (ram_we),
    .waddr   (wptr),
    .wdata   ({lane_valid, lane_dat}),
    .re      (issue_rd),
    .raddr   (raddr),
    .rdata   (rdata)
  );

  assign start_addr = trig_addr - PRE_OFS;
  assign raddr      = start_addr + rd_cnt[ADDR_BITS-1:0];
  assign emit       = cur_valid && (!dout_valid || dout_ready);
  assign last_byte  = (lane_idx == LANE_LAST) && (dig_idx == DIG_SEP);
  assign load_cur   = nxt_valid && (!cur_valid || (emit && last_byte));
  // a new read may overwrite the RAM output reg only once its word has moved on
  assign issue_rd   = (state == DRAIN) && !rd_cnt[ADDR_BITS] && (!nxt_valid || load_cur);
  assign drain_done = dout_valid && dout_ready && out_last;

  always_comb begin
    lane_bits = '0;
    lane_ok   = 1'b0;
    nib       = 4'd0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (lane_idx == LANE_W'(i)) begin
        lane_bits[LANE_WIDTH-1:0] = cur_word[i*LANE_WIDTH +: LANE_WIDTH];
        lane_ok                   = cur_word[NUM_LANES*LANE_WIDTH + i];
      end
    end
    for (int d = 0; d < HEX_DIGITS; d++) begin
      if (dig_idx == DIG_W'(d)) nib = lane_bits[(HEX_DIGITS-1-d)*4 +: 4];
    end
    if (dig_idx == DIG_SEP) byte_nxt = (lane_idx == LANE_LAST) ? ASC_LF : ASC_SPACE;
    else if (!lane_ok)      byte_nxt = ASC_X;
    else                    byte_nxt = nibble_to_ascii(nib);
  end

  always_ff @(posedge clk_sys or negedge arst_sys_n) begin
    if (!arst_sys_n) begin
      rd_cnt     <= '0;
      nxt_valid  <= 1'b0;
      nxt_last   <= 1'b0;
      cur_valid  <= 1'b0;
      cur_last   <= 1'b0;
      cur_word   <= '0;
      lane_idx   <= '0;
      dig_idx    <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      out_last   <= 1'b0;
    end else if (state != DRAIN) begin
      rd_cnt     <= '0;
      nxt_valid  <= 1'b0;
      nxt_last   <= 1'b0;
      cur_valid  <= 1'b0;
      cur_last   <= 1'b0;
      lane_idx   <= '0;
      dig_idx    <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      out_last   <= 1'b0;
    end else begin
      if (issue_rd) begin
        rd_cnt   <= rd_cnt + 1'b1;
        nxt_last <= &rd_cnt[ADDR_BITS-1:0];
      end
      if (issue_rd)      nxt_valid <= 1'b1;
      else if (load_cur) nxt_valid <= 1'b0;

      if (load_cur) begin
        cur_word  <= rdata;
        cur_last  <= nxt_last;
        cur_valid <= 1'b1;
      end else if (emit && last_byte) begin
        cur_valid <= 1'b0;
      end

      if (emit) begin
        dout       <= byte_nxt;
        dout_valid <= 1'b1;
        out_last   <= cur_last && last_byte;
        if (dig_idx == DIG_SEP) begin
          dig_idx  <= '0;
          lane_idx <= (lane_idx == LANE_LAST) ? '0 : lane_idx + 1'b1;
        end else begin
          dig_idx <= dig_idx + 1'b1;
        end
      end else if (dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_n_lane_capture_probe.sv
// Directed bench for n_lane_capture_probe: 2 lanes x 8 bits, 16-deep memory, PRE_TRIG 4, pause 4.
module tb_n_lane_capture_probe;

  logic        clk_sys = 1'b0;
  logic        arst_sys_n;
  logic [15:0] lane_dat;
  logic [1:0]  lane_valid;
  logic        arm_en;
  logic [7:0]  trig_pattern;
  logic [7:0]  trig_mask;
  logic [1:0]  trig_lane_en;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        reporting;
  logic        triggered;

  int n_checks = 0;
  int n_fail   = 0;

  // first lane-0 value in the window; counter restarts at 0 when arm_en rises
`ifdef N_LANE_CAPTURE_PROBE_TRIGGER_EN
  localparam logic [7:0] START_TRIG  = 8'h05;
  localparam logic [7:0] START_EARLY = 8'hFD;
`else
  localparam logic [7:0] START_TRIG  = 8'h04;
  localparam logic [7:0] START_EARLY = 8'h04;
`endif

  always #5 clk_sys = ~clk_sys;

  n_lane_capture_probe #(
    .NUM_LANES    (2),
    .LANE_WIDTH   (8),
    .ADDR_BITS    (4),
    .PRE_TRIG     (4),
    .PAUSE_CYCLES (4)
  ) dut (
    .clk_sys      (clk_sys),
    .arst_sys_n   (arst_sys_n),
    .lane_dat     (lane_dat),
    .lane_valid   (lane_valid),
    .arm_en       (arm_en),
    .trig_pattern (trig_pattern),
    .trig_mask    (trig_mask),
    .trig_lane_en (trig_lane_en),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .dout_ready   (dout_ready),
    .reporting    (reporting),
    .triggered    (triggered)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'd0, n}) : (8'h37 + {4'd0, n});
  endfunction

  function automatic logic [47:0] exp_line(input logic [7:0] v, input logic ok1);
    return {hexc(v[7:4]), hexc(v[3:0]), 8'h20, (ok1 ? 16'h4141 : 16'h5858), 8'h0A};
  endfunction

  // Called at a negedge with the DUT idle. Raises arm_en with lane 0 counting from 0,
  // collects 96 bytes and checks the 16 lines. rst_at > 0 resets the DUT after that many bytes.
  task automatic run_harvest(input string tag, input logic [7:0] pattern, input logic [1:0] lane_en,
                             input logic valid1, input bit bp, input logic [7:0] start, input int rst_at);
    logic [7:0] bytes [96];
    int         nbytes = 0;
    int         cyc = 0;
    logic [7:0] cnt = 8'd0;
    bit         hold_pend = 0;
    logic [7:0] hold_val = 8'd0;
    int         rep_cyc = -1;
    int         val_cyc = -1;
    bit         trig_seen = 0;
    bit         trig_before_rep = 0;
    bit         rep_at_last = 0;
    logic [47:0] line;
    trig_pattern = pattern;
    trig_lane_en = lane_en;
    arm_en       = 1'b1;
    while (nbytes < 96 && cyc < 2000) begin
      if (hold_pend) check_val({tag, "_hold"}, {55'd0, dout_valid, dout}, {55'd0, 1'b1, hold_val});
      if (triggered) begin
        trig_seen = 1;
        arm_en    = 1'b0;
      end
      if (reporting && rep_cyc < 0) begin
        rep_cyc         = cyc;
        trig_before_rep = trig_seen;
      end
      if (dout_valid && val_cyc < 0) val_cyc = cyc;
      dout_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      hold_pend  = dout_valid && !dout_ready;
      hold_val   = dout;
      if (dout_valid && dout_ready) begin
        if (rst_at > 0 && nbytes == rst_at) begin
          arst_sys_n = 1'b0;
          arm_en     = 1'b0;
          #1;
          check_val({tag, "_rst_out"}, {53'd0, dout, dout_valid, reporting, triggered}, 64'd0);
          return;
        end
        bytes[nbytes] = dout;
        nbytes++;
        rep_at_last = reporting;
      end
      lane_dat   = {8'hAA, cnt};
      lane_valid = {valid1, 1'b1};
      cnt++;
      @(negedge clk_sys);
      cyc++;
    end
    check_val({tag, "_nbytes"}, 64'(nbytes), 64'd96);
    check_val({tag, "_rep_last"}, {63'd0, rep_at_last}, 64'd1);
    check_val({tag, "_end"}, {61'd0, reporting, triggered, dout_valid}, 64'd0);
    check_val({tag, "_trig"}, {63'd0, trig_before_rep}, 64'd1);
    check_val({tag, "_lat"}, 64'((rep_cyc >= 0) && (val_cyc >= rep_cyc) && (val_cyc - rep_cyc <= 3)), 64'd1);
    for (int k = 0; k < 16; k++) begin
      line = {bytes[6*k], bytes[6*k+1], bytes[6*k+2], bytes[6*k+3], bytes[6*k+4], bytes[6*k+5]};
      check_val($sformatf("%s_line%0d", tag, k), {16'd0, line}, {16'd0, exp_line(8'(start + 8'(k)), valid1)});
    end
  endtask

  initial begin
    bit ab_bad;
    arst_sys_n   = 1'b0;
    arm_en       = 1'b0;
    lane_dat     = '0;
    lane_valid   = '0;
    trig_pattern = '0;
    trig_mask    = 8'hFF;
    trig_lane_en = '0;
    dout_ready   = 1'b0;
    repeat (3) @(negedge clk_sys);
    check_val("reset", {53'd0, dout, dout_valid, reporting, triggered}, 64'd0);
    arst_sys_n = 1'b1;
    repeat (6) @(negedge clk_sys);
    check_val("idle_hold", {61'd0, reporting, triggered, dout_valid}, 64'd0);

    run_harvest("basic", 8'h09, 2'b11, 1'b1, 0, START_TRIG, 0);
    repeat (3) @(negedge clk_sys);
    run_harvest("early", 8'h01, 2'b01, 1'b1, 0, START_EARLY, 0);
    repeat (3) @(negedge clk_sys);
    run_harvest("inval", 8'h09, 2'b11, 1'b0, 0, START_TRIG, 0);
    repeat (3) @(negedge clk_sys);
    run_harvest("bp", 8'h09, 2'b11, 1'b1, 1, START_TRIG, 0);
    repeat (3) @(negedge clk_sys);

    // abort: drop arm_en two cycles into ARM, then present a matching sample
    trig_pattern = 8'h09;
    trig_lane_en = 2'b11;
    dout_ready   = 1'b1;
    arm_en       = 1'b1;
    for (int i = 0; i < 6; i++) begin
      lane_dat   = {8'hAA, 8'(i)};
      lane_valid = 2'b11;
      @(negedge clk_sys);
    end
    arm_en = 1'b0;
    ab_bad = 0;
    for (int i = 0; i < 20; i++) begin
      lane_dat = {8'hAA, 8'h09};
      @(negedge clk_sys);
      if (reporting || triggered) ab_bad = 1;
    end
    check_val("abort_quiet", {63'd0, ab_bad}, 64'd0);
    run_harvest("rearm", 8'h09, 2'b11, 1'b1, 0, START_TRIG, 0);
    repeat (3) @(negedge clk_sys);

    run_harvest("rst_drain", 8'h09, 2'b11, 1'b1, 0, START_TRIG, 10);
    repeat (2) @(negedge clk_sys);
    check_val("rst_hold", {53'd0, dout, dout_valid, reporting, triggered}, 64'd0);
    arst_sys_n = 1'b1;
    repeat (2) @(negedge clk_sys);
    run_harvest("post_rst", 8'h09, 2'b11, 1'b1, 0, START_TRIG, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
